// File: rtl/uart_tx_fifo_if.sv
// Write port bundle for uart_tx_fifo: valid/ready byte handshake.
//   i_TX_DV    : write request from the producer
//   i_TX_Byte  : write data, DATA_WIDTH bits
//   o_TX_Ready : transmitter FIFO can accept a write this cycle
// master = byte producer, slave = transmitter.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  i_TX_DV;
    logic [DATA_WIDTH-1:0] i_TX_Byte;
    logic                  o_TX_Ready;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO.
// Build-time data width; runtime baud divisor, parity and stop-bit count,
// all sampled when a frame starts. Back-to-back frames leave no idle gap.
// Ports:
//   i_Clock, i_Rst_L     : clock, synchronous active-low reset
//   wr (slave)           : i_TX_DV / i_TX_Byte / o_TX_Ready write port
//   i_Clks_Per_Bit       : clocks per bit (0 treated as 1)
//   i_Parity_En          : append parity bit after data
//   i_Parity_Odd         : odd (1) or even (0) parity
//   i_Two_Stop           : two stop bits (1) or one (0)
//   o_FIFO_Count         : entries held in the FIFO
//   o_TX_Active          : frame in progress
//   o_TX_Serial          : serial line, idle high
//   o_TX_Done            : one-cycle pulse at the end of each frame
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    uart_tx_fifo_if.slave                 wr,
    input  logic [CNT_W-1:0]              i_Clks_Per_Bit,
    input  logic                          i_Parity_En,
    input  logic                          i_Parity_Odd,
    input  logic                          i_Two_Stop,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // frame state
    logic [2:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [CNT_W-1:0]      cpb_q,      cpb_d;
    logic [IW-1:0]         idx_q,      idx_d;
    logic                  stop2_q,    stop2_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic                  two_stop_q, two_stop_d;
    logic                  serial_q,   serial_d;
    logic                  active_q,   active_d;
    logic                  done_q,     done_d;

    // FIFO state
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]         count_q,    count_d;
    logic                  ready_q,    ready_d;

    logic                  push;
    logic                  pop;
    logic                  start_frame;
    logic                  bit_end;
    logic                  fifo_nonempty;
    logic [DATA_WIDTH-1:0] head;

    // Next-state logic for the frame sequencer and FIFO.
    always_comb begin
        state_d     = state_q;
        cpb_d       = cpb_q;
        idx_d       = idx_q;
        stop2_d     = stop2_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        two_stop_d  = two_stop_q;
        serial_d    = serial_q;
        active_d    = active_q;
        done_d      = 1'b0;
        start_frame = 1'b0;
        pop         = 1'b0;

        push          = wr.i_TX_DV && ready_q;
        head          = mem_q[rd_ptr_q];
        fifo_nonempty = (count_q != '0);
        bit_end       = (cnt_q == (cpb_q - CNT_W'(1)));
        cnt_d         = bit_end ? '0 : (cnt_q + CNT_W'(1));

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                if (fifo_nonempty) begin
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                    idx_d    = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d  = S_PARITY;
                            serial_d = par_bit_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                            stop2_d  = 1'b0;
                        end
                    end else begin
                        idx_d    = idx_q + IW'(1);
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                    stop2_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (fifo_nonempty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            serial_d = 1'b1;
                            active_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
            end
        endcase

        // Frame start: pop head and latch this frame's configuration.
        if (start_frame) begin
            pop        = 1'b1;
            state_d    = S_START;
            shift_d    = head;
            cpb_d      = (i_Clks_Per_Bit == '0) ? CNT_W'(1) : i_Clks_Per_Bit;
            par_en_d   = i_Parity_En;
            par_bit_d  = (^head) ^ i_Parity_Odd;
            two_stop_d = i_Two_Stop;
            serial_d   = 1'b0;
            active_d   = 1'b1;
            cnt_d      = '0;
            idx_d      = '0;
            stop2_d    = 1'b0;
        end

        // Circular buffer; power-of-two depth lets pointers wrap naturally.
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr.i_TX_Byte;
        end
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ready_d  = (count_d < CW'(FIFO_DEPTH));
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cpb_q      <= '0;
            idx_q      <= '0;
            stop2_q    <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpb_q      <= cpb_d;
            idx_q      <= idx_d;
            stop2_q    <= stop2_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            mem_q      <= mem_d;
        end
    end

    assign wr.o_TX_Ready = ready_q;
    assign o_FIFO_Count  = count_q;
    assign o_TX_Active   = active_q;
    assign o_TX_Serial   = serial_q;
    assign o_TX_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit and 5-bit builds.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpb;
    logic        pe, po, ts;
    logic [2:0]  count;
    logic        active, serial, done;

    logic [15:0] cpb5;
    logic        pe5, po5, ts5;
    logic [2:0]  count5;
    logic        active5, serial5, done5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_WIDTH(8)) wr_if ();
    uart_tx_fifo_if #(.DATA_WIDTH(5)) wr5_if ();

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_W(16)) u_dut (
        .i_Clock        (clk),
        .i_Rst_L        (rst_n),
        .wr             (wr_if.slave),
        .i_Clks_Per_Bit (cpb),
        .i_Parity_En    (pe),
        .i_Parity_Odd   (po),
        .i_Two_Stop     (ts),
        .o_FIFO_Count   (count),
        .o_TX_Active    (active),
        .o_TX_Serial    (serial),
        .o_TX_Done      (done)
    );

    uart_tx_fifo #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .CNT_W(16)) u_dut5 (
        .i_Clock        (clk),
        .i_Rst_L        (rst_n),
        .wr             (wr5_if.slave),
        .i_Clks_Per_Bit (cpb5),
        .i_Parity_En    (pe5),
        .i_Parity_Odd   (po5),
        .i_Two_Stop     (ts5),
        .o_FIFO_Count   (count5),
        .o_TX_Active    (active5),
        .o_TX_Serial    (serial5),
        .o_TX_Done      (done5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk one 8-bit frame from cycle 'skip' (cycle 0 = first start-bit cycle)
    // and finish on the edge that ends the last stop bit.
    task automatic run_frame(input string tag, input logic [7:0] data, input int cpbe,
                             input logic p_en, input logic p_odd, input logic two,
                             input int skip);
        logic [11:0] bits;
        int          nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        nb = 9;
        if (p_en) begin
            bits[nb] = (^data) ^ p_odd;
            nb++;
        end
        nb += two ? 2 : 1;
        for (int k = skip; k < nb * cpbe; k++) begin
            check({tag, "_line"}, serial, bits[k / cpbe]);
            check({tag, "_active"}, active, 1'b1);
            if (k != 0) check({tag, "_done_low"}, done, 1'b0);
            tick();
        end
        check({tag, "_done_pulse"}, done, 1'b1);
    endtask

    task automatic idle_after(input string tag);
        check({tag, "_idle_active"}, active, 1'b0);
        check({tag, "_idle_line"}, serial, 1'b1);
        tick();
        check({tag, "_done_clear"}, done, 1'b0);
        check({tag, "_idle_line2"}, serial, 1'b1);
    endtask

    task automatic write_and_start(input logic [7:0] data);
        wr_if.i_TX_DV   = 1'b1;
        wr_if.i_TX_Byte = data;
        tick();
        wr_if.i_TX_DV = 1'b0;
        check("wr_count1", count, 3'd1);
        check("wr_line_idle", serial, 1'b1);
        check("wr_active0", active, 1'b0);
        tick();
        check("pop_count0", count, 3'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d6 [6];
        logic [2:0] exp_cnt [6];
        logic [7:0] exp5;

        rst_n            = 1'b0;
        cpb              = 16'd4;
        pe               = 1'b0;
        po               = 1'b0;
        ts               = 1'b0;
        wr_if.i_TX_DV    = 1'b0;
        wr_if.i_TX_Byte  = 8'h00;
        cpb5             = 16'd2;
        pe5              = 1'b1;
        po5              = 1'b1;
        ts5              = 1'b0;
        wr5_if.i_TX_DV   = 1'b0;
        wr5_if.i_TX_Byte = 5'h00;
        tick();
        tick();

        // reset state
        check("rst_line", serial, 1'b1);
        check("rst_active", active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", wr_if.o_TX_Ready, 1'b1);
        check("rst_count", count, 3'd0);
        check("rst5_line", serial5, 1'b1);
        check("rst5_count", count5, 3'd0);
        rst_n = 1'b1;
        tick();

        // 0xA5, divisor 4, 8N1
        write_and_start(8'hA5);
        run_frame("a5_8n1", 8'hA5, 4, 1'b0, 1'b0, 1'b0, 0);
        idle_after("a5_8n1");

        // even parity
        pe = 1'b1;
        write_and_start(8'hA5);
        run_frame("a5_even", 8'hA5, 4, 1'b1, 1'b0, 1'b0, 0);
        idle_after("a5_even");

        // odd parity, two stop bits
        po = 1'b1;
        ts = 1'b1;
        write_and_start(8'hA5);
        run_frame("a5_odd2", 8'hA5, 4, 1'b1, 1'b1, 1'b1, 0);
        idle_after("a5_odd2");
        pe = 1'b0;
        po = 1'b0;
        ts = 1'b0;

        // six consecutive writes, divisor 2
        cpb     = 16'd2;
        d6      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int i = 0; i < 6; i++) begin
            check("burst_ready", wr_if.o_TX_Ready, (i < 5) ? 1'b1 : 1'b0);
            wr_if.i_TX_DV   = 1'b1;
            wr_if.i_TX_Byte = d6[i];
            tick();
            check("burst_count", count, exp_cnt[i]);
        end
        wr_if.i_TX_DV = 1'b0;
        for (int f = 0; f < 5; f++) begin
            run_frame("burst", d6[f], 2, 1'b0, 1'b0, 1'b0, (f == 0) ? 4 : 0);
            check("burst_count_after", count, (f < 4) ? 3'(3 - f) : 3'd0);
        end
        idle_after("burst");
        for (int i = 0; i < 30; i++) begin
            check("burst_no_sixth", serial, 1'b1);
            tick();
        end

        // divisor changed mid-frame
        cpb             = 16'd4;
        wr_if.i_TX_DV   = 1'b1;
        wr_if.i_TX_Byte = 8'h3C;
        tick();
        wr_if.i_TX_Byte = 8'hC3;
        tick();
        wr_if.i_TX_DV = 1'b0;
        cpb           = 16'd8;
        check("div_count", count, 3'd1);
        run_frame("div_old", 8'h3C, 4, 1'b0, 1'b0, 1'b0, 0);
        check("div_count0", count, 3'd0);
        run_frame("div_new", 8'hC3, 8, 1'b0, 1'b0, 1'b0, 0);
        idle_after("div_new");

        // divisor 0 behaves as 1
        cpb = 16'd0;
        write_and_start(8'h5A);
        run_frame("div0", 8'h5A, 1, 1'b0, 1'b0, 1'b0, 0);
        idle_after("div0");

        // reset mid-DATA with two bytes queued
        cpb             = 16'd4;
        wr_if.i_TX_DV   = 1'b1;
        wr_if.i_TX_Byte = 8'hF0;
        tick();
        wr_if.i_TX_Byte = 8'h0F;
        tick();
        wr_if.i_TX_Byte = 8'h81;
        tick();
        wr_if.i_TX_DV = 1'b0;
        check("rstmid_count2", count, 3'd2);
        for (int i = 0; i < 6; i++) tick();
        check("rstmid_active", active, 1'b1);
        check("rstmid_databit0", serial, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid_line", serial, 1'b1);
        check("rstmid_active0", active, 1'b0);
        check("rstmid_count0", count, 3'd0);
        check("rstmid_ready", wr_if.o_TX_Ready, 1'b1);
        check("rstmid_done", done, 1'b0);
        for (int i = 0; i < 60; i++) begin
            tick();
            check("rstmid_quiet_line", serial, 1'b1);
            check("rstmid_quiet_done", done, 1'b0);
            check("rstmid_quiet_active", active, 1'b0);
        end

        // 5-bit build: 5'h13, odd parity, divisor 2
        // line: start 0, data 1,1,0,0,1, parity 0, stop 1
        exp5             = 8'hA6;
        wr5_if.i_TX_DV   = 1'b1;
        wr5_if.i_TX_Byte = 5'h13;
        tick();
        wr5_if.i_TX_DV = 1'b0;
        check("w5_count1", count5, 3'd1);
        tick();
        for (int k = 0; k < 16; k++) begin
            check("w5_line", serial5, exp5[k / 2]);
            check("w5_active", active5, 1'b1);
            if (k != 0) check("w5_done_low", done5, 1'b0);
            tick();
        end
        check("w5_done_pulse", done5, 1'b1);
        check("w5_idle_active", active5, 1'b0);
        tick();
        check("w5_idle_line", serial5, 1'b1);
        check("w5_done_clear", done5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised successor to the team's fixed 8N1 UART transmitter. Data width is set at build time; baud divisor, parity and stop-bit count are set at runtime. A small transmit FIFO with a valid/ready write port supports back-to-back frames with no idle gap. The block sits between a byte-producing core (CPU bridge, packetiser) and the serial pin, and pairs with the existing UART receiver.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the baud divisor input.
- i_Clock  in  1  single clock; all logic on rising edge.
- i_Rst_L  in  1  reset; synchronous, active-low.
- i_Clks_Per_Bit  in  CNT_W  clocks per bit; value 0 is treated as 1.
- i_Parity_En  in  1  1 = parity bit appended after data.
- i_Parity_Odd  in  1  1 = odd parity, 0 = even (ignored if !i_Parity_En).
- i_Two_Stop  in  1  1 = two stop bits, 0 = one.
- i_TX_DV  in  1  write request.
- i_TX_Byte  in  DATA_WIDTH  write data.
- o_TX_Ready  out  1  FIFO can accept a write (count < FIFO_DEPTH).
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  entries held.
- o_TX_Active  out  1  frame in progress.
- o_TX_Serial  out  1  serial line; idle high.
- o_TX_Done  out  1  one-cycle pulse at end of each frame.

## Operation
- Write accepted on an edge where i_TX_DV && o_TX_Ready. Writes while not ready are dropped, with no other effect.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: line high. If FIFO is non-empty, pop the head into the shift register and latch i_Clks_Per_Bit, i_Parity_En, i_Parity_Odd and i_Two_Stop. Then go to START, driving the line 0 and o_TX_Active 1.
- Config inputs are sampled only at frame start. Changes mid-frame take effect on the next frame.
- START: one bit time low, then DATA.
- DATA: DATA_WIDTH bits, LSB first, each for one bit time. Then PARITY if enabled, else STOP.
- PARITY: one bit time. Even parity = XOR of data bits; odd parity = its inverse.
- STOP: line high for 1 or 2 bit times. At the final edge:
  - pulse o_TX_Done;
  - if FIFO is non-empty, pop and enter START directly (no idle cycle, o_TX_Active stays 1);
  - else go to IDLE with o_TX_Active 0.
- Bit time = max(i_Clks_Per_Bit, 1) clocks, counted by a CNT_W-bit counter that resets to 0 at each bit boundary.
- Frame length = bit time × (1 + DATA_WIDTH + P + S), with P ∈ {0,1} and S ∈ {1,2}.
- FIFO: circular buffer with read/write pointers.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap at FIFO_DEPTH.
  - o_TX_Ready depends on the registered count only; a push on a full FIFO is refused even if a pop occurs on the same edge.
- Illegal state encodings return to IDLE with the line high.

## Timing
- Reset values (on any edge with i_Rst_L = 0):
  - state IDLE;
  - o_TX_Serial 1, o_TX_Active 0, o_TX_Done 0;
  - o_TX_Ready 1, o_FIFO_Count 0;
  - counters and pointers 0.
- Reset mid-frame aborts the frame and flushes the FIFO; the line is high after that edge. No o_TX_Done is emitted for the aborted frame.
- Write on edge N into an empty FIFO while IDLE: o_FIFO_Count = 1 after N; pop at edge N+1; o_TX_Serial = 0 and o_TX_Active = 1 after N+1.
- Each bit occupies exactly bit-time cycles, with no jitter between bits.
- o_TX_Done is high for exactly one cycle, coincident with the edge that ends the last stop bit.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- DATA_WIDTH=8, divisor 4, no parity, 1 stop, write 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. o_TX_Done pulses 40 cycles after the start bit begins; line idles high afterwards.
- Same byte with parity on → even: parity bit 0; odd: parity bit 1; frame is 44 cycles. With i_Two_Stop also set → 48 cycles and the line is high for the last 8.
- FIFO_DEPTH=4, divisor 2, six consecutive i_TX_DV cycles starting at edge N:
  - count after N = 1, after N+1 = 1, after N+2 = 2, after N+3 = 3, after N+4 = 4;
  - o_TX_Ready is 0 at edge N+5, so the sixth write is refused;
  - five frames go out back-to-back with no high gap between a stop bit and the next start bit;
  - o_TX_Done pulses 5 times and o_TX_Active stays 1 throughout.
- Divisor changed from 4 to 8 mid-frame → current frame keeps 4-cycle bits; the next queued frame uses 8-cycle bits. Divisor 0 → 1-cycle bits.
- i_Rst_L low for one edge mid-DATA with 2 bytes queued → line high, o_TX_Active 0, o_FIFO_Count 0 and o_TX_Ready 1 after that edge. No o_TX_Done, no further frames.
- DATA_WIDTH=5 build, write 5'h13 with odd parity → data bits 1,1,0,0,1 then parity 0 (three ones), then a 1-bit stop.
